// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage. Picks the register-file write value from the ALU
// result, a control-register read, a scalar load, a block vector load or one
// strided/gather lane. Detects load cache misses, suppresses the write,
// requests a rollback of the strand and keeps that strand suspended until its
// cache fill completes.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   instruction_i .. was_access_i  registered outputs of the memory stage
//   data_i, cache_hit_i          L1 data cache read port
//   load_complete_strands_i      one-hot fill-complete per strand
//   writeback_*_o                register-file write port (1-cycle latency)
//   rollback_*_o                 strand restart request (1-cycle pulse)
//   suspend_strands_o            strands waiting on a fill
//
// Per-strand suspend FSM
//   state     | meaning
//   RUN       | strand free to issue
//   WAIT_FILL | strand missed, waiting for load_complete_strands_i
module writeback_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instruction_i,
    input  logic [1:0]   strand_i,
    input  logic [31:0]  pc_i,
    input  logic         has_writeback_i,
    input  logic [6:0]   writeback_reg_i,
    input  logic         writeback_is_vector_i,
    input  logic [15:0]  mask_i,
    input  logic [511:0] result_i,
    input  logic [3:0]   reg_lane_select_i,
    input  logic [3:0]   cache_lane_select_i,
    input  logic         was_access_i,
    input  logic [511:0] data_i,
    input  logic         cache_hit_i,
    input  logic [3:0]   load_complete_strands_i,
    output logic         writeback_enable_o,
    output logic [6:0]   writeback_reg_o,
    output logic         writeback_is_vector_o,
    output logic [511:0] writeback_value_o,
    output logic [15:0]  writeback_mask_o,
    output logic         rollback_request_o,
    output logic [1:0]   rollback_strand_o,
    output logic [31:0]  rollback_pc_o,
    output logic [3:0]   rollback_lane_o,
    output logic [3:0]   suspend_strands_o
);

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_FILL = 1'b1
    } strand_state_t;

    strand_state_t strand_state [4];

    logic         is_fmt_c;
    logic         is_load;
    logic [3:0]   op;
    logic [31:0]  cache_word;
    logic [31:0]  load_word;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [31:0]  scalar_value;
    logic [511:0] value;
    logic [15:0]  value_mask;
    logic         miss;
    logic [3:0]   miss_strands;

    assign is_fmt_c = instruction_i[31:30] == 2'b10;
    assign is_load  = is_fmt_c && instruction_i[29];
    assign op       = instruction_i[28:25];

    // Lane 0 sits in the most significant word of the line.
    always_comb begin
        cache_word = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (cache_lane_select_i == 4'(i))
                cache_word = data_i[511 - 32*i -: 32];
        end
    end

    // Memory words are stored byte-reversed relative to register order.
    assign load_word = {cache_word[7:0], cache_word[15:8],
                        cache_word[23:16], cache_word[31:24]};

    always_comb begin
        case (result_i[1:0])
            2'd0:    byte_sel = cache_word[7:0];
            2'd1:    byte_sel = cache_word[15:8];
            2'd2:    byte_sel = cache_word[23:16];
            default: byte_sel = cache_word[31:24];
        endcase
        half_sel = result_i[1] ? load_word[15:0] : load_word[31:16];
    end

    always_comb begin
        case (op)
            4'b0000: scalar_value = {24'd0, byte_sel};
            4'b0001: scalar_value = {{24{byte_sel[7]}}, byte_sel};
            4'b0010: scalar_value = {16'd0, half_sel};
            4'b0011: scalar_value = {{16{half_sel[15]}}, half_sel};
            default: scalar_value = load_word;
        endcase
    end

    always_comb begin
        value      = result_i;
        value_mask = mask_i;
        if (is_load) begin
            case (op)
                4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                    value      = {480'd0, scalar_value};
                    value_mask = 16'hFFFF;
                end
                4'b0111, 4'b1000, 4'b1001: begin
                    for (int i = 0; i < 16; i++) begin
                        value[32*i +: 32] = {data_i[32*i +: 8], data_i[32*i + 8 +: 8],
                                             data_i[32*i + 16 +: 8], data_i[32*i + 24 +: 8]};
                    end
                end
                4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                    value      = {16{load_word}};
                    value_mask = mask_i & (16'h8000 >> reg_lane_select_i);
                end
                default: ; // control register: ALU path carries the value
            endcase
        end
    end

    // Control-register reads never touch the cache, so they cannot miss.
    assign miss         = is_load && was_access_i && !cache_hit_i && op != 4'b0110;
    assign miss_strands = miss ? (4'b0001 << strand_i) : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            writeback_enable_o    <= 1'b0;
            writeback_reg_o       <= 7'd0;
            writeback_is_vector_o <= 1'b0;
            writeback_value_o     <= 512'd0;
            writeback_mask_o      <= 16'd0;
            rollback_request_o    <= 1'b0;
            rollback_strand_o     <= 2'd0;
            rollback_pc_o         <= 32'd0;
            rollback_lane_o       <= 4'd0;
        end else begin
            writeback_enable_o    <= has_writeback_i && !miss && instruction_i != 32'd0;
            writeback_reg_o       <= writeback_reg_i;
            writeback_is_vector_o <= writeback_is_vector_i;
            writeback_value_o     <= value;
            writeback_mask_o      <= value_mask;
            rollback_request_o    <= miss;
            if (miss) begin
                rollback_strand_o <= strand_i;
                rollback_pc_o     <= pc_i - 32'd4;
                rollback_lane_o   <= reg_lane_select_i;
            end
        end
    end

    // A new miss takes priority over a fill for the same strand.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (reset) begin
                strand_state[s]      <= RUN;
                suspend_strands_o[s] <= 1'b0;
            end else begin
                case (strand_state[s])
                    RUN: begin
                        if (miss_strands[s]) begin
                            strand_state[s]      <= WAIT_FILL;
                            suspend_strands_o[s] <= 1'b1;
                        end
                    end
                    default: begin
                        if (!miss_strands[s] && load_complete_strands_i[s]) begin
                            strand_state[s]      <= RUN;
                            suspend_strands_o[s] <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  instruction_i = '0;
    logic [1:0]   strand_i = '0;
    logic [31:0]  pc_i = '0;
    logic         has_writeback_i = 1'b0;
    logic [6:0]   writeback_reg_i = '0;
    logic         writeback_is_vector_i = 1'b0;
    logic [15:0]  mask_i = '0;
    logic [511:0] result_i = '0;
    logic [3:0]   reg_lane_select_i = '0;
    logic [3:0]   cache_lane_select_i = '0;
    logic         was_access_i = 1'b0;
    logic [511:0] data_i = '0;
    logic         cache_hit_i = 1'b0;
    logic [3:0]   load_complete_strands_i = '0;
    logic         writeback_enable_o;
    logic [6:0]   writeback_reg_o;
    logic         writeback_is_vector_o;
    logic [511:0] writeback_value_o;
    logic [15:0]  writeback_mask_o;
    logic         rollback_request_o;
    logic [1:0]   rollback_strand_o;
    logic [31:0]  rollback_pc_o;
    logic [3:0]   rollback_lane_o;
    logic [3:0]   suspend_strands_o;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .reset(reset),
        .instruction_i(instruction_i), .strand_i(strand_i), .pc_i(pc_i),
        .has_writeback_i(has_writeback_i), .writeback_reg_i(writeback_reg_i),
        .writeback_is_vector_i(writeback_is_vector_i), .mask_i(mask_i),
        .result_i(result_i), .reg_lane_select_i(reg_lane_select_i),
        .cache_lane_select_i(cache_lane_select_i), .was_access_i(was_access_i),
        .data_i(data_i), .cache_hit_i(cache_hit_i),
        .load_complete_strands_i(load_complete_strands_i),
        .writeback_enable_o(writeback_enable_o), .writeback_reg_o(writeback_reg_o),
        .writeback_is_vector_o(writeback_is_vector_o),
        .writeback_value_o(writeback_value_o), .writeback_mask_o(writeback_mask_o),
        .rollback_request_o(rollback_request_o), .rollback_strand_o(rollback_strand_o),
        .rollback_pc_o(rollback_pc_o), .rollback_lane_o(rollback_lane_o),
        .suspend_strands_o(suspend_strands_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: expected registered outputs and suspended strands.
    logic         e_en, e_vec, e_rb;
    logic [6:0]   e_reg;
    logic [511:0] e_val;
    logic [15:0]  e_mask;
    logic [1:0]   e_rbs;
    logic [31:0]  e_rbpc;
    logic [3:0]   e_rblane;
    logic [3:0]   m_susp;

    initial begin
        e_rb = 0; e_rbs = 0; e_rbpc = 0; e_rblane = 0; m_susp = 0;
    end

    function automatic logic [31:0] bswap(input logic [31:0] x);
        logic [31:0] r = 0;
        for (int k = 0; k < 4; k++)
            r = r | (((x >> (8*k)) & 32'hFF) << (24 - 8*k));
        return r;
    endfunction

    // Compute expectations from the current inputs, clock once, compare.
    task automatic step();
        int          op;
        bit          ld, miss;
        logic [31:0] wd, lw, sv;
        logic [511:0] full;
        if (reset) begin
            e_en = 0; e_reg = 0; e_vec = 0; e_val = 0; e_mask = 0;
            e_rb = 0; e_rbs = 0; e_rbpc = 0; e_rblane = 0; m_susp = 0;
        end else begin
            op   = int'(instruction_i[28:25]);
            ld   = instruction_i[31:29] == 3'b101;
            full = data_i >> (32 * (15 - int'(cache_lane_select_i)));
            wd   = full[31:0];
            lw   = bswap(wd);
            miss = ld && was_access_i && !cache_hit_i && op != 6;
            e_en  = has_writeback_i && !miss && instruction_i != 0;
            e_reg = writeback_reg_i;
            e_vec = writeback_is_vector_i;
            e_val = result_i; e_mask = mask_i;
            if (ld && op <= 5) begin
                if (op <= 1) begin
                    sv = (wd >> (8 * int'(result_i[1:0]))) & 32'hFF;
                    if (op == 1 && sv >= 128) sv = sv + 32'hFFFFFF00;
                end else if (op <= 3) begin
                    sv = result_i[1] ? lw % 65536 : lw / 65536;
                    if (op == 3 && sv >= 32768) sv = sv + 32'hFFFF0000;
                end else sv = lw;
                e_val = {480'd0, sv}; e_mask = 16'hFFFF;
            end else if (ld && op >= 7 && op <= 9) begin
                e_val = 0;
                for (int i = 0; i < 16; i++) begin
                    full = data_i >> (32*i);
                    e_val = e_val | ({480'd0, bswap(full[31:0])} << (32*i));
                end
            end else if (ld && op >= 10) begin
                e_val = 0;
                for (int i = 0; i < 16; i++) e_val = e_val | ({480'd0, lw} << (32*i));
                e_mask = mask_i & 16'(1 << (15 - int'(reg_lane_select_i)));
            end
            e_rb = miss;
            if (miss) begin
                e_rbs = strand_i; e_rbpc = pc_i - 4; e_rblane = reg_lane_select_i;
            end
            for (int s = 0; s < 4; s++) begin
                if (miss && int'(strand_i) == s) m_susp[s] = 1;
                else if (load_complete_strands_i[s]) m_susp[s] = 0;
            end
        end
        @(posedge clk); #1;
        check("wb_enable", writeback_enable_o, e_en);
        check("wb_reg", writeback_reg_o, e_reg);
        check("wb_is_vector", writeback_is_vector_o, e_vec);
        check("wb_value", writeback_value_o, e_val);
        check("wb_mask", writeback_mask_o, e_mask);
        check("rb_request", rollback_request_o, e_rb);
        check("rb_strand", rollback_strand_o, e_rbs);
        check("rb_pc", rollback_pc_o, e_rbpc);
        check("rb_lane", rollback_lane_o, e_rblane);
        check("suspend", suspend_strands_o, m_susp);
    endtask

    task automatic load(input logic [3:0] op, input logic [31:0] w, input int cls, input logic hit);
        instruction_i = {3'b101, op, 25'h0ABC};
        data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        data_i[511 - 32*cls -: 32] = w;
        cache_lane_select_i = 4'(cls);
        has_writeback_i = 1; was_access_i = 1; cache_hit_i = hit;
        writeback_reg_i = 7'h15;
    endtask

    initial begin
        step();                                   // reset state
        check("reset_value", writeback_value_o, 512'd0);
        reset = 0;
        strand_i = 0; mask_i = 16'hFFFF; load_complete_strands_i = 0;

        // 1: signed byte load
        load(4'b0001, 32'h11803344, 3, 1); result_i = 512'h2;
        step();
        check("tp1_value", writeback_value_o[31:0], 32'hFFFFFF80);
        check("tp1_enable", writeback_enable_o, 1'b1);

        // 2: unsigned half, upper address half; then word
        load(4'b0010, 32'hAABBCCDD, 9, 1); result_i = 512'h2;
        step();
        check("tp2_half", writeback_value_o[31:0], 32'h0000BBAA);
        load(4'b0100, 32'hAABBCCDD, 0, 1); result_i = 512'h0;
        step();
        check("tp2_word", writeback_value_o[31:0], 32'hDDCCBBAA);

        // 3: gather lane 5
        load(4'b1101, 32'h01020304, 5, 1); reg_lane_select_i = 5; writeback_is_vector_i = 1;
        step();
        check("tp3_mask", writeback_mask_o, 16'h0400);
        check("tp3_value", writeback_value_o, {16{32'h04030201}});

        // block vector load
        load(4'b1000, 32'h0, 0, 1); mask_i = 16'h5A5A;
        step();
        writeback_is_vector_i = 0; mask_i = 16'hFFFF;

        // 4: miss on strand 2, then wait for fill
        load(4'b0100, 32'h12345678, 2, 0); strand_i = 2; pc_i = 32'h1004; reg_lane_select_i = 7;
        step();
        check("tp4_pc", rollback_pc_o, 32'h1000);
        check("tp4_susp", suspend_strands_o, 4'b0100);
        instruction_i = 0; has_writeback_i = 0; was_access_i = 0;
        step(); step();
        check("tp4_pulse_gone", rollback_request_o, 1'b0);
        load_complete_strands_i = 4'b0100; instruction_i = 0; has_writeback_i = 0;
        step();
        check("tp4_cleared", suspend_strands_o, 4'b0000);
        load_complete_strands_i = 0;

        // 5: miss and fill on strand 1 together; store with no hit
        load(4'b0000, 32'h0, 1, 0); strand_i = 1; pc_i = 32'h0;
        step();
        check("tp5_wrap", rollback_pc_o, 32'hFFFFFFFC);
        load(4'b0000, 32'h0, 1, 0); load_complete_strands_i = 4'b0010;
        step();
        check("tp5_stay", suspend_strands_o, 4'b0010);
        load_complete_strands_i = 4'b0010; instruction_i = {3'b100, 4'b0100, 25'h0};
        step();
        check("tp5_store_no_rb", rollback_request_o, 1'b0);
        load_complete_strands_i = 0;

        // 6: reset while strands 0 and 3 suspended and a miss pending
        load(4'b0100, 32'h0, 4, 0); strand_i = 0; step();
        load(4'b0100, 32'h0, 4, 0); strand_i = 3; step();
        load(4'b0100, 32'h0, 4, 0); strand_i = 1; reset = 1;
        step();
        check("tp6_susp", suspend_strands_o, 4'b0000);
        check("tp6_rb", rollback_request_o, 1'b0);
        reset = 0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: instruction_i = 0;
                1: instruction_i = {$urandom_range(0, 4) == 0 ? 3'b100 : 3'($urandom_range(0, 4)), 29'($urandom)};
                default: instruction_i = {3'b101, 4'($urandom), 25'($urandom)};
            endcase
            strand_i = 2'($urandom); pc_i = $urandom;
            has_writeback_i = 1'($urandom); writeback_reg_i = 7'($urandom);
            writeback_is_vector_i = 1'($urandom); mask_i = 16'($urandom);
            result_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            reg_lane_select_i = 4'($urandom); cache_lane_select_i = 4'($urandom);
            was_access_i = $urandom_range(0, 3) != 0; cache_hit_i = $urandom_range(0, 2) != 0;
            load_complete_strands_i = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'd0;
            reset = $urandom_range(0, 59) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage; directly downstream of the memory access stage, whose registered outputs it consumes alongside the L1 data cache read port.
- Selects the register-file write value: ALU result, control-register read, scalar load (aligned, byte-swapped, extended), block vector load, or one strided/gather lane.
- Detects load cache misses, suppresses the writeback, issues a rollback, and holds a per-strand suspend flag until the miss fill completes.

Parameters:
(none)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high
instruction_i  input  32  instruction from memory access stage (0 = NOP)
strand_i  input  2  issuing strand
pc_i  input  32  address of the instruction following this one
has_writeback_i  input  1  instruction writes a register
writeback_reg_i  input  7  destination register
writeback_is_vector_i  input  1  destination is a vector register
mask_i  input  16  lane mask, bit 15 = lane 0
result_i  input  512  ALU result / effective address / control-register value
reg_lane_select_i  input  4  current lane for strided/gather
cache_lane_select_i  input  4  word index within cache line
was_access_i  input  1  a cache access was issued for this instruction
data_i  input  512  cache line read data, valid this cycle
cache_hit_i  input  1  cache hit for this access
load_complete_strands_i  input  4  one-hot: fill finished for strand(s)
writeback_enable_o  output  1  register-file write strobe
writeback_reg_o  output  7  destination register
writeback_is_vector_o  output  1  vector destination
writeback_value_o  output  512  write data
writeback_mask_o  output  16  per-lane write enable (vector only)
rollback_request_o  output  1  restart strand
rollback_strand_o  output  2  strand to restart
rollback_pc_o  output  32  restart PC
rollback_lane_o  output  4  lane to resume at (strided/gather)
suspend_strands_o  output  4  strands blocked on a fill

Behaviour:
- Decode:
  - is_fmt_c = instruction_i[31:30]==2'b10.
  - is_load = instruction_i[31:29]==3'b101.
  - op = instruction_i[28:25]:
    - 0000/0001: byte unsigned/signed
    - 0010/0011: half unsigned/signed
    - 0100: word
    - 0101: synchronized word
    - 0110: control register
    - 0111–1001: block vector
    - 1010–1100: strided
    - 1101–1111: gather
- Cache word w = data_i word at cache_lane_select_i; lane 0 is bits [511:480]. The word is stored byte-reversed, so the loaded value L = {w[7:0], w[15:8], w[23:16], w[31:24]}.
- Scalar load, using address byte result_i[1:0]:
  - Byte: select byte b of w (b = 0 is w[7:0]); zero- or sign-extend to 32 bits.
  - Half: result_i[1]=0 uses L[31:16], result_i[1]=1 uses L[15:0]; zero- or sign-extend.
  - Word / synchronized word: L.
  - The 32-bit result goes in value[31:0]; upper bits are 0. Mask = 16'hFFFF.
- Block vector load: each of the 16 words byte-reversed in place; mask = mask_i.
- Strided/gather load: value = {16{L}}; mask = mask_i & (16'h8000 >> reg_lane_select_i).
- Control-register load and non-load instructions: value = result_i; mask = mask_i.
- miss = is_load && was_access_i && !cache_hit_i && op != 0110. Stores never miss.
- All outputs are registered with 1-cycle latency from the inputs.
- writeback_enable_o <= has_writeback_i && !miss && instruction_i != 0.
- On miss, next cycle, held for exactly 1 cycle:
  - rollback_request_o = 1
  - rollback_strand_o = strand_i
  - rollback_pc_o = pc_i - 4 (32-bit wrap)
  - rollback_lane_o = reg_lane_select_i
- Otherwise rollback_request_o = 0 and the other rollback outputs hold their last value.
- Per-strand suspend state machine, one per strand:
  - States: RUN and WAIT_FILL.
  - RUN -> WAIT_FILL on a miss from that strand.
  - WAIT_FILL -> RUN when the strand's load_complete_strands_i bit is 1.
  - Fill and new miss for the same strand in the same cycle: WAIT_FILL wins.
  - A fill bit for a strand already in RUN is ignored.
  - suspend_strands_o bit = 1 in WAIT_FILL.
- Reset: all outputs 0, all strands RUN.
  - Reset overrides a concurrent miss.
  - Reset asserted mid-WAIT_FILL returns the strand to RUN.

Test Plan:
1. Byte signed load: op 0001, result_i[1:0]=2, w=32'h11_80_33_44 -> writeback_value_o[31:0]=32'hFFFFFF80, enable=1 one cycle after input.
2. Half unsigned load: result_i[1]=1, w=32'hAABBCCDD -> value 32'h0000BBAA. Word load of the same w -> 32'hDDCCBBAA.
3. Gather load: lane 5, mask_i=16'hFFFF, w=32'h01020304 -> mask=16'h0400, every lane value 32'h04030201.
4. Miss: strand 2, pc_i=32'h1004, lane 7, cache_hit_i=0 -> enable=0; rollback pulse for 1 cycle with pc=32'h1000, strand 2, lane 7; suspend_strands_o=4'b0100 until load_complete_strands_i=4'b0100, cleared the following cycle.
5. Simultaneous miss on strand 1 while fill bit 1 asserted -> strand 1 stays suspended. Store with cache_hit_i=0 -> no rollback.
6. Reset asserted while strands 0 and 3 are suspended and a miss is in flight -> all outputs 0, suspend_strands_o=0, no rollback pulse.
